// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial bit source feeding a 1011 sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clock,
// MSB- or LSB-first per word, streaming back-to-back words without gap bits.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   din, din_valid  - word to serialize and its valid strobe
//   msb_first       - bit order for the word being accepted (1 = MSB first)
//   din_ready       - a word can be accepted this cycle
//   seq_out         - serial bit (IDLE_BIT between words)
//   seq_valid       - seq_out carries a word bit
//   word_done       - high during the last bit of a word
//   bits_left       - bits remaining in the current word, including seq_out
//   words_sent      - count of fully emitted words, wraps 255 -> 0
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       msb_first,
    output logic                       din_ready,
    output logic                       seq_out,
    output logic                       seq_valid,
    output logic                       word_done,
    output logic [$clog2(WIDTH+1)-1:0] bits_left,
    output logic [7:0]                 words_sent
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             order_msb;
    logic             last_bit;
    logic             xfer;

    assign last_bit  = (state == SHIFT) && (bits_left == CW'(1));

    // Ready depends only on state and reset so there is no valid->ready path.
    assign din_ready = !rst && ((state == IDLE) || last_bit);
    assign xfer      = din_valid && din_ready;

    assign seq_valid = (state == SHIFT);
    assign word_done = last_bit;

    always_comb begin
        seq_out = IDLE_BIT;
        if (state == SHIFT) begin
            seq_out = order_msb ? shreg[WIDTH-1] : shreg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            order_msb  <= 1'b0;
            bits_left  <= '0;
            words_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg     <= din;
                        order_msb <= msb_first;
                        bits_left <= CW'(WIDTH);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        shreg     <= order_msb ? (shreg << 1) : (shreg >> 1);
                        bits_left <= bits_left - CW'(1);
                    end else begin
                        words_sent <= words_sent + 8'd1;
                        // A word accepted on the last-bit edge follows with no idle bit.
                        if (xfer) begin
                            shreg     <= din;
                            order_msb <= msb_first;
                            bits_left <= CW'(WIDTH);
                            state     <= SHIFT;
                        end else begin
                            shreg     <= '0;
                            bits_left <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial bit-stream source that sits directly upstream of the 1011 sequence detector and drives its `seq_in`. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB-first or LSB-first as selected per word. Back-to-back words stream with no gap bits, and a fixed idle level is driven between words. The block also reports word boundaries and a running count of words sent.

## Interface
- `WIDTH`, 8: word width in bits, legal range 2..32.
- `IDLE_BIT`, 1'b0: level driven on `seq_out` while no word is in flight.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `din` input WIDTH: word to serialize.
- `din_valid` input 1: `din` holds a word for transfer.
- `msb_first` input 1: bit order, sampled only on an accepted transfer. 1 = MSB first, 0 = LSB first.
- `din_ready` output 1: block can accept a word this cycle.
- `seq_out` output 1: serial bit, connects to the detector's `seq_in`.
- `seq_valid` output 1: `seq_out` carries a word bit, not idle fill.
- `word_done` output 1: high during the last bit of a word.
- `bits_left` output $clog2(WIDTH+1): bits remaining in the current word, including the bit on `seq_out`.
- `words_sent` output 8: count of fully emitted words, wraps at 255 to 0.

## Operation
- Two states, encoded IDLE=1'b0 and SHIFT=1'b1.
- A transfer occurs on a rising edge where `din_valid && din_ready` and `rst` is 0.
- `din_ready`:
  - 0 while `rst` is 1.
  - Otherwise 1 in IDLE, and 1 in SHIFT when `bits_left==1`.
  - 0 otherwise.
  - It is combinational from state and `rst` only, with no path from `din_valid`.
- On a transfer, the edge performs these updates:
  - shift register <= `din`
  - order flag <= `msb_first`
  - `bits_left` <= WIDTH
  - state <= SHIFT
- In SHIFT with `bits_left>1`, each edge shifts the register by one position toward the output end and decrements `bits_left`.
  - MSB-first shifts left and the output end is bit WIDTH-1.
  - LSB-first shifts right and the output end is bit 0.
  - Vacated positions fill with 0.
- In SHIFT with `bits_left==1`, each edge does the following:
  - `words_sent` increments, wrapping 255 to 0.
  - If a transfer occurs in the same edge, the new word loads per the transfer rule and the state stays SHIFT, so there is no idle bit between words.
  - Otherwise state <= IDLE and `bits_left` <= 0.
- `seq_out` is combinational:
  - In SHIFT, it is the output-end bit of the shift register per the latched order flag.
  - In IDLE, it is `IDLE_BIT`.
- `seq_valid` = (state==SHIFT).
- `word_done` = (state==SHIFT && `bits_left==1`).
- `din` and `msb_first` are ignored outside transfer edges. Changing them mid-word has no effect.
- `din_valid` held high while `din_ready` is 0 is not an error. The word waits and transfers on the first edge where `din_ready` is 1.
- Reset, which also applies mid-word, takes effect on the next edge while `rst` is 1:
  - state IDLE
  - shift register 0
  - `bits_left` 0
  - `words_sent` 0
- Any partially emitted word is discarded and not counted.
- Output values in reset: `seq_out`=`IDLE_BIT`, `seq_valid`=0, `word_done`=0, `din_ready`=0, `bits_left`=0, `words_sent`=0.

## Timing
- Latency from a transfer at edge k:
  - First word bit is on `seq_out` in the cycle after edge k.
  - Bit i (0-based) is present in the cycle after edge k+i.
  - The detector samples bit i at edge k+i+1.
- A word occupies exactly WIDTH consecutive cycles.
- Streaming throughput is 1 bit per clock with no bubbles when `din_valid` is high at every edge where `bits_left==1`.
- The first edge after `rst` deasserts can accept a transfer.
- Between words, the detector receives `IDLE_BIT` every clock. With `IDLE_BIT`=0, a 1011 pattern split across an idle gap is deliberately broken.

## Test plan
- Reset, then `din`=8'hB0 with `msb_first`=1 and `din_valid` for one edge:
  - `seq_out` = 1,0,1,1,0,0,0,0 on cycles 1..8.
  - `word_done` is high on cycle 8 only.
  - `words_sent`=1.
  - The downstream detector's `det_out` rises exactly once.
- `din`=8'h0D with `msb_first`=0: `seq_out` = 1,0,1,1,0,0,0,0, and `bits_left` steps 8→1 then 0.
- Back-to-back 8'hB6, 8'hB6 with `din_valid` held high:
  - 16 contiguous valid bits with no idle bit.
  - `din_ready` is high only on cycle 8, then only on cycle 16.
  - `words_sent`=2.
- Assert `rst` for one cycle at bit 4 of 8'hFF:
  - Next cycle `seq_valid`=0, `seq_out`=0, `words_sent`=0, `din_ready`=0 during reset.
  - A new word is accepted on the next edge after reset.
- Toggle `din` and `msb_first` during a word: the emitted bits match the word latched at transfer.
- Stream 256 words back-to-back: `words_sent` wraps 255→0 on the 256th word's last-bit edge.
